// File: rtl/adder.sv
// Unsigned WIDTH-bit ripple-carry adder with a full-precision combinational
// sum and a one-cycle registered copy carrying valid and overflow flags.
module adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   sum_q,
    output logic             out_valid,
    output logic             ovf_q
);
    logic [WIDTH:0] c;
    logic           ovf;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        adder_fa u_fa (
            .a (A[i]),
            .b (B[i]),
            .ci(c[i]),
            .s (sum[i]),
            .co(c[i+1])
        );
    end

    assign sum[WIDTH] = c[WIDTH];

    // Signed overflow: like-signed operands whose truncated sum flips sign.
    assign ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q <= sum;
                ovf_q <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: combinational sum, registered path, async
// reset, and operand sweeps at WIDTH 4, 1 and 16.
module tb_adder;
    logic        clk;
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        in_valid;
    logic [4:0]  sum;
    logic [4:0]  sum_q;
    logic        out_valid;
    logic        ovf_q;

    logic        a1, b1;
    logic [1:0]  sum1, sum_q1;
    logic        ov1, ovf1;
    logic [15:0] a16, b16;
    logic [16:0] sum16, sum_q16;
    logic        ov16, ovf16;
    logic        idle;

    int passed = 0;
    int total  = 0;

    adder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(in_valid),
        .sum(sum), .sum_q(sum_q), .out_valid(out_valid), .ovf_q(ovf_q)
    );

    adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(idle),
        .sum(sum1), .sum_q(sum_q1), .out_valid(ov1), .ovf_q(ovf1)
    );

    adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .in_valid(idle),
        .sum(sum16), .sum_q(sum_q16), .out_valid(ov16), .ovf_q(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if (sum_q !== 5'd0 || out_valid !== 1'b0 || ovf_q !== 1'b0)
            $display("FAIL reset_state: sum_q=%0d ov=%b ovf=%b want 0 0 0",
                     sum_q, out_valid, ovf_q);
        else passed++;
        // capture must stay blocked while rst is held
        @(negedge clk);
        a = 4'd5; b = 4'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || sum_q !== 5'd0)
            $display("FAIL reset_blocks_capture: ov=%b sum_q=%0d want 0 0",
                     out_valid, sum_q);
        else passed++;
        total++;
        if (sum !== 5'd11)
            $display("FAIL reset_comb_live: got %0d want 11", sum);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        for (int k = 0; k < 8; k++) begin
            a = 4'(k); b = 4'(k);
            #1;
            total++;
            if (sum !== 5'(2 * k))
                $display("FAIL ramp k=%0d: got %0d want %0d", k, sum, 2 * k);
            else passed++;
            #9;
        end
    endtask

    task automatic test_extremes();
        a = 4'd15; b = 4'd15; #1;
        total++;
        if (sum !== 5'b11110)
            $display("FAIL max_max: got %0d want 30", sum);
        else passed++;
        a = 4'd15; b = 4'd0; #1;
        total++;
        if (sum !== 5'd15)
            $display("FAIL max_zero: got %0d want 15", sum);
        else passed++;
        a = 4'd0; b = 4'd0; #1;
        total++;
        if (sum !== 5'd0)
            $display("FAIL zero_zero: got %0d want 0", sum);
        else passed++;
        @(negedge clk);
        a = 4'd8; b = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sum_q !== 5'd16 || ovf_q !== 1'b1)
            $display("FAIL ovf_8_8: sum_q=%0d ovf=%b want 16 1", sum_q, ovf_q);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        a = 4'd3; b = 4'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sum_q !== 5'd7 || out_valid !== 1'b1 || ovf_q !== 1'b0)
            $display("FAIL latency_capture: sum_q=%0d ov=%b ovf=%b want 7 1 0",
                     sum_q, out_valid, ovf_q);
        else passed++;
        @(negedge clk);
        a = 4'd9; b = 4'd2; in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (sum_q !== 5'd7 || out_valid !== 1'b0)
            $display("FAIL latency_hold: sum_q=%0d ov=%b want 7 0",
                     sum_q, out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            a = 4'(k); b = 4'(k); in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if (sum_q !== 5'(2 * k) || out_valid !== 1'b1)
                $display("FAIL stream k=%0d: sum_q=%0d ov=%b want %0d 1",
                         k, sum_q, out_valid, 2 * k);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (sum_q !== 5'd0 || ovf_q !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL async_reset: sum_q=%0d ovf=%b ov=%b want 0 0 0",
                     sum_q, ovf_q, out_valid);
        else passed++;
        a = 4'd6; b = 4'd7; #1;
        total++;
        if (sum !== 5'd13)
            $display("FAIL async_reset_comb: got %0d want 13", sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || sum_q !== 5'd0)
            $display("FAIL no_replay: ov=%b sum_q=%0d want 0 0",
                     out_valid, sum_q);
        else passed++;
        @(negedge clk);
        a = 4'd1; b = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sum_q !== 5'd3 || out_valid !== 1'b1)
            $display("FAIL first_capture: sum_q=%0d ov=%b want 3 1",
                     sum_q, out_valid);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_exhaustive4();
        int errs = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a = 4'(i); b = 4'(j); #1;
                total++;
                if (sum !== 5'(i + j)) begin
                    errs++;
                    if (errs < 8)
                        $display("FAIL w4 %0d+%0d: got %0d want %0d",
                                 i, j, sum, i + j);
                end else passed++;
            end
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a1 = 1'(i); b1 = 1'(j); #1;
                exp = 2'(i + j);
                total++;
                if (sum1 !== exp)
                    $display("FAIL w1 %0d+%0d: got %0d want %0d",
                             i, j, sum1, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_width16();
        logic [16:0] exp;
        int errs = 0;
        for (int n = 0; n < 200; n++) begin
            if (n == 0) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF;
            end else if (n == 1) begin
                a16 = 16'h8000; b16 = 16'h8000;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom);
            end
            #1;
            exp = {1'b0, a16} + {1'b0, b16};
            total++;
            if (sum16 !== exp) begin
                errs++;
                if (errs < 8)
                    $display("FAIL w16 %h+%h: got %h want %h",
                             a16, b16, sum16, exp);
            end else passed++;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; idle = 1'b0;
        a = '0; b = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_ramp();
        test_extremes();
        test_latency();
        test_back_to_back();
        test_async_reset();
        test_exhaustive4();
        test_width1();
        test_width16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
